dm_core_ram: RTL and testbench



---
 rtl/dm_pkg.sv | 15 +
 rtl/dm_core_ram_if.sv | 24 ++
 rtl/dm_byte_merge.sv | 24 ++
 rtl/dm_core_ram.sv | 62 ++++++
 tb/tb_dm_core_ram.sv | 146 ++++++++++++++
 5 files changed

// File: rtl/dm_pkg.sv
// rtl/dm_pkg.sv - shared constants for the data-memory core
// Purpose: default geometry of the data memory and the read-during-write
//          mode encodings used by the WRITE_MODE parameter.
// Ports:   none (package).
package dm_pkg;

  localparam int DM_ADDR_WIDTH = 11;
  localparam int DM_DATA_WIDTH = 32;
  localparam int DM_NUM_BYTES  = DM_DATA_WIDTH / 8;

  localparam int WM_WRITE_FIRST = 0;
  localparam int WM_READ_FIRST  = 1;
  localparam int WM_NO_CHANGE   = 2;

endpackage

// File: rtl/dm_core_ram_if.sv
// rtl/dm_core_ram_if.sv - access bus of the data-memory core
// Purpose: bundles the enable, byte write enables, address, write data and
//          registered read data of the single memory port.
// Ports:   master drives ena/wea/addra/dina and samples douta;
//          slave (the memory) samples the request and drives douta.
interface dm_core_ram_if
  import dm_pkg::*;
#(
  parameter int ADDR_WIDTH = DM_ADDR_WIDTH,
  parameter int DATA_WIDTH = DM_DATA_WIDTH
);

  localparam int NUM_BYTES = DATA_WIDTH / 8;

  logic                  ena;
  logic [NUM_BYTES-1:0]  wea;
  logic [ADDR_WIDTH-1:0] addra;
  logic [DATA_WIDTH-1:0] dina;
  logic [DATA_WIDTH-1:0] douta;

  modport master (output ena, output wea, output addra, output dina, input douta);
  modport slave  (input ena, input wea, input addra, input dina, output douta);

endinterface

// File: rtl/dm_byte_merge.sv
// rtl/dm_byte_merge.sv - byte-lane merge of old and new memory words
// Purpose: produces the post-write word: lanes with wea set take new_word,
//          the others keep old_word.
// Ports:   old_word (current contents), new_word (write data),
//          wea (byte enables), merged (post-write word).
module dm_byte_merge
  import dm_pkg::*;
#(
  parameter int DATA_WIDTH = DM_DATA_WIDTH
) (
  input  logic [DATA_WIDTH-1:0]   old_word,
  input  logic [DATA_WIDTH-1:0]   new_word,
  input  logic [DATA_WIDTH/8-1:0] wea,
  output logic [DATA_WIDTH-1:0]   merged
);

  always_comb begin
    merged = old_word;
    for (int i = 0; i < DATA_WIDTH / 8; i++) begin
      if (wea[i]) merged[8*i +: 8] = new_word[8*i +: 8];
    end
  end

endmodule

// File: rtl/dm_core_ram.sv
// rtl/dm_core_ram.sv - single-port data memory with byte write enables
// Purpose: 2**ADDR_WIDTH x DATA_WIDTH synchronous RAM with one-cycle
//          registered read and selectable read-during-write behaviour.
// Ports:   clka (clock), rsta_n (synchronous active-low reset, clears douta
//          only), bus (slave side: ena, wea, addra, dina, douta).
module dm_core_ram
  import dm_pkg::*;
#(
  parameter int                    ADDR_WIDTH = DM_ADDR_WIDTH,
  parameter int                    DATA_WIDTH = DM_DATA_WIDTH,
  parameter int                    WRITE_MODE = WM_WRITE_FIRST,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
  input logic          clka,
  input logic          rsta_n,
  dm_core_ram_if.slave bus
);

  localparam int NUM_BYTES = DATA_WIDTH / 8;
  localparam int DEPTH     = 2 ** ADDR_WIDTH;

  // Configuration-time contents; reset deliberately leaves the array alone.
  logic [DATA_WIDTH-1:0] mem [DEPTH] = '{default: INIT_VALUE};

  logic [DATA_WIDTH-1:0] rd_word;
  logic [DATA_WIDTH-1:0] merged;
  logic                  wr_any;

  assign rd_word = mem[bus.addra];
  assign wr_any  = (bus.wea != '0);

  dm_byte_merge #(.DATA_WIDTH(DATA_WIDTH)) u_merge (
    .old_word (rd_word),
    .new_word (bus.dina),
    .wea      (bus.wea),
    .merged   (merged)
  );

  always_ff @(posedge clka) begin
    if (rsta_n && bus.ena && wr_any) mem[bus.addra] <= merged;
  end

  // Read port: a pure read always returns the stored word; on a write the
  // mode decides between the merged word, the old word or holding.
  always_ff @(posedge clka) begin
    if (!rsta_n) begin
      bus.douta <= '0;
    end else if (bus.ena) begin
      if (!wr_any) begin
        bus.douta <= rd_word;
      end else if (WRITE_MODE == WM_WRITE_FIRST) begin
        bus.douta <= merged;
      end else if (WRITE_MODE == WM_READ_FIRST) begin
        bus.douta <= rd_word;
      end
    end
  end

  logic unused_num_bytes;
  assign unused_num_bytes = (NUM_BYTES == 0);

endmodule

// File: tb/tb_dm_core_ram.sv
// tb/tb_dm_core_ram.sv - bench for dm_core_ram in all three write modes
module tb_dm_core_ram;

  logic clka = 1'b0;
  logic rsta_n;

  always #5 clka = ~clka;

  dm_core_ram_if bus_wf ();
  dm_core_ram_if bus_rf ();
  dm_core_ram_if bus_nc ();

  dm_core_ram #(.WRITE_MODE(0)) u_wf (.clka(clka), .rsta_n(rsta_n), .bus(bus_wf));
  dm_core_ram #(.WRITE_MODE(1)) u_rf (.clka(clka), .rsta_n(rsta_n), .bus(bus_rf));
  dm_core_ram #(.WRITE_MODE(2)) u_nc (.clka(clka), .rsta_n(rsta_n), .bus(bus_nc));

  int checks = 0;
  int errors = 0;

  logic [31:0] ref_mem [2048];
  logic [31:0] exp_wf, exp_rf, exp_nc;

  task automatic check_one(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check_one({tag, "/wf"}, bus_wf.douta, exp_wf);
    check_one({tag, "/rf"}, bus_rf.douta, exp_rf);
    check_one({tag, "/nc"}, bus_nc.douta, exp_nc);
  endtask

  // One clock edge: drive all three ports identically, advance the
  // reference model by the rules of the memory, then compare.
  task automatic step(input string tag, input logic rst_n, input logic en,
                      input logic [3:0] we, input logic [10:0] addr, input logic [31:0] din);
    logic [31:0] mask, old_w, new_w;
    @(negedge clka);
    rsta_n = rst_n;
    bus_wf.ena = en; bus_wf.wea = we; bus_wf.addra = addr; bus_wf.dina = din;
    bus_rf.ena = en; bus_rf.wea = we; bus_rf.addra = addr; bus_rf.dina = din;
    bus_nc.ena = en; bus_nc.wea = we; bus_nc.addra = addr; bus_nc.dina = din;
    @(posedge clka);
    #1;
    if (!rst_n) begin
      exp_wf = 0; exp_rf = 0; exp_nc = 0;
    end else if (en) begin
      mask  = {{8{we[3]}}, {8{we[2]}}, {8{we[1]}}, {8{we[0]}}};
      old_w = ref_mem[addr];
      new_w = (old_w & ~mask) | (din & mask);
      ref_mem[addr] = new_w;
      if (we == 4'h0) begin
        exp_wf = old_w; exp_rf = old_w; exp_nc = old_w;
      end else begin
        exp_wf = new_w; exp_rf = old_w;
      end
    end
    check_all(tag);
  endtask

  logic [31:0] lane_exp [4];
  logic [31:0] rnd_data [8];

  initial begin
    for (int i = 0; i < 2048; i++) ref_mem[i] = 32'h0;
    exp_wf = 0; exp_rf = 0; exp_nc = 0;
    lane_exp[0] = 32'hAABBCC11; lane_exp[1] = 32'hAABB11DD;
    lane_exp[2] = 32'hAA11CCDD; lane_exp[3] = 32'h11BBCCDD;

    // Reset blocks writes and clears douta
    step("rst0", 1'b0, 1'b1, 4'hF, 11'd5, 32'hFFFFFFFF);
    step("rst1", 1'b0, 1'b1, 4'hF, 11'd5, 32'hFFFFFFFF);
    check_one("rst_lit", bus_wf.douta, 32'h0);
    step("rd5", 1'b1, 1'b1, 4'h0, 11'd5, 32'h0);
    check_one("rd5_lit", bus_wf.douta, 32'h0);

    // Partial write
    step("pw", 1'b1, 1'b1, 4'b1100, 11'd1002, 32'h12345678);
    check_one("pw_lit", bus_wf.douta, 32'h12340000);
    step("pw_rd", 1'b1, 1'b1, 4'h0, 11'd1002, 32'h0);
    check_one("pw_rd_lit", bus_rf.douta, 32'h12340000);

    // Per-lane independence
    for (int l = 0; l < 4; l++) begin
      step("lane_full", 1'b1, 1'b1, 4'hF, 11'd7, 32'hAABBCCDD);
      step("lane_one", 1'b1, 1'b1, 4'(1 << l), 11'd7, 32'h11 << (8 * l));
      step("lane_rd", 1'b1, 1'b1, 4'h0, 11'd7, 32'h0);
      check_one("lane_lit", bus_nc.douta, lane_exp[l]);
    end

    // Enable gating
    step("en_wr", 1'b1, 1'b1, 4'hF, 11'd3, 32'hDEADBEEF);
    step("en_off", 1'b1, 1'b0, 4'hF, 11'd3, 32'h0);
    check_one("en_hold_lit", bus_wf.douta, 32'hDEADBEEF);
    step("en_rd", 1'b1, 1'b1, 4'h0, 11'd3, 32'h0);
    check_one("en_rd_lit", bus_nc.douta, 32'hDEADBEEF);

    // Read-during-write modes; NO_CHANGE keeps the unrelated previous read
    step("md_init", 1'b1, 1'b1, 4'hF, 11'd10, 32'h11111111);
    step("md_prev", 1'b1, 1'b1, 4'h0, 11'd3, 32'h0);
    step("md_wr", 1'b1, 1'b1, 4'hF, 11'd10, 32'h22222222);
    check_one("md_wf_lit", bus_wf.douta, 32'h22222222);
    check_one("md_rf_lit", bus_rf.douta, 32'h11111111);
    check_one("md_nc_lit", bus_nc.douta, 32'hDEADBEEF);

    // Address boundaries
    step("b0_wr", 1'b1, 1'b1, 4'hF, 11'd0, 32'hA5A5A5A5);
    step("bN_wr", 1'b1, 1'b1, 4'hF, 11'd2047, 32'h5A5A5A5A);
    step("b0_rd", 1'b1, 1'b1, 4'h0, 11'd0, 32'h0);
    check_one("b0_lit", bus_wf.douta, 32'hA5A5A5A5);
    step("bN_rd", 1'b1, 1'b1, 4'h0, 11'd2047, 32'h0);
    check_one("bN_lit", bus_wf.douta, 32'h5A5A5A5A);

    // Back-to-back consecutive reads
    for (int i = 0; i < 8; i++) begin
      rnd_data[i] = $urandom;
      step("b2b_wr", 1'b1, 1'b1, 4'hF, 11'(100 + i), rnd_data[i]);
    end
    for (int i = 0; i < 8; i++) begin
      step("b2b_rd", 1'b1, 1'b1, 4'h0, 11'(100 + i), $urandom);
      check_one("b2b_lit", bus_rf.douta, rnd_data[i]);
    end

    // Reset released mid-stream: first edge after is a normal write
    step("mid_rst", 1'b0, 1'b1, 4'hF, 11'd20, 32'hCAFEF00D);
    step("mid_wr", 1'b1, 1'b1, 4'b0011, 11'd20, 32'hCAFEF00D);
    check_one("mid_lit", bus_wf.douta, 32'h0000F00D);

    // Randomized traffic over a small window plus the top address
    for (int n = 0; n < 400; n++) begin
      logic [10:0] a;
      a = ($urandom_range(0, 9) == 0) ? 11'd2047 : 11'($urandom_range(0, 15));
      step("rand", ($urandom_range(0, 31) != 0), ($urandom_range(0, 5) != 0),
           ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom), a, $urandom);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
